// File: rtl/brd_reset_button_if.sv
// -----------------------------------------------------------------------------
// brd_reset_button_if
//   Bundles the board-side signals of the reset push-button conditioner.
//
//   i_btn_raw        raw button pin, asynchronous and bouncing
//   o_brd_rst        registered active-high board reset
//   o_btn_level      debounced button state, 1 = pressed
//   o_press_pulse    one-cycle strobe on debounced press
//   o_release_pulse  one-cycle strobe on debounced release
//   o_state          conditioner FSM state for debug
//
//   master : the conditioner itself (samples the pin, drives the reset)
//   slave  : the board side (drives the pin, consumes the reset)
// -----------------------------------------------------------------------------
interface brd_reset_button_if;
  logic       i_btn_raw;
  logic       o_brd_rst;
  logic       o_btn_level;
  logic       o_press_pulse;
  logic       o_release_pulse;
  logic [1:0] o_state;

  modport master (
    input  i_btn_raw,
    output o_brd_rst,
    output o_btn_level,
    output o_press_pulse,
    output o_release_pulse,
    output o_state
  );

  modport slave (
    output i_btn_raw,
    input  o_brd_rst,
    input  o_btn_level,
    input  o_press_pulse,
    input  o_release_pulse,
    input  o_state
  );
endinterface

// File: rtl/brd_reset_button.sv
// -----------------------------------------------------------------------------
// brd_reset_button
//   Turns the raw board reset push-button into a clean, glitch-free,
//   active-high board reset for the clocks/resets block. Reset is also held
//   for RST_HOLD_CNT cycles after power-up and after every button release.
//
//   i_brd_clk    board crystal clock, the only clock
//   i_brd_rst_n  asynchronous active-low reset
//   bus          brd_reset_button_if.master
//                  i_btn_raw in; o_brd_rst, o_btn_level, o_press_pulse,
//                  o_release_pulse, o_state out
//
//   Parameters
//     DEBOUNCE_CNT    stable cycles needed to accept a level change (>= 2)
//     RST_HOLD_CNT    reset hold cycles after power-up / release (>= 1)
//     BTN_ACTIVE_LOW  1 when the raw pin reads 0 while pressed
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   POR     | power-up hold, reset asserted while hold counter runs
//   RUN     | reset released, waiting for a debounced press
//   PRESSED | button held down, reset asserted
//   STRETCH | button released, reset held for RST_HOLD_CNT more cycles
// -----------------------------------------------------------------------------
module brd_reset_button #(
  parameter int unsigned DEBOUNCE_CNT   = 1000000,
  parameter int unsigned RST_HOLD_CNT   = 256,
  parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
  input  logic               i_brd_clk,
  input  logic               i_brd_rst_n,
  brd_reset_button_if.master bus
);

  localparam int DB_W   = $clog2(DEBOUNCE_CNT);
  localparam int HOLD_W = $clog2(RST_HOLD_CNT) + 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CNT - 1);

  typedef enum logic [1:0] {
    ST_POR     = 2'd0,
    ST_RUN     = 2'd1,
    ST_PRESSED = 2'd2,
    ST_STRETCH = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser. Held at the idle pin level in reset so that the
  // first debounce after reset always starts from "not pressed".
  // ---------------------------------------------------------------------------
  logic btn_s1;
  logic btn_s2;
  logic pressed;

  always_ff @(posedge i_brd_clk or negedge i_brd_rst_n) begin
    if (!i_brd_rst_n) begin
      btn_s1 <= BTN_ACTIVE_LOW;
      btn_s2 <= BTN_ACTIVE_LOW;
    end else begin
      btn_s1 <= bus.i_btn_raw;
      btn_s2 <= btn_s1;
    end
  end

  assign pressed = btn_s2 ^ BTN_ACTIVE_LOW;

  // ---------------------------------------------------------------------------
  // Debounce: count consecutive cycles where the synchronised level differs
  // from the accepted one. Any agreeing cycle restarts the count, and the
  // count is consumed at DB_LAST, so the counter cannot wrap.
  // ---------------------------------------------------------------------------
  logic [DB_W-1:0] db_cnt;
  logic            btn_level;

  always_ff @(posedge i_brd_clk or negedge i_brd_rst_n) begin
    if (!i_brd_rst_n) begin
      db_cnt    <= '0;
      btn_level <= 1'b0;
    end else if (pressed == btn_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      btn_level <= pressed;
      db_cnt    <= '0;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Edge strobes, one cycle after the accepted level changes. Only one of
  // the two can be set per cycle since they decode opposite edges.
  // ---------------------------------------------------------------------------
  logic level_q;
  logic press_pulse;
  logic release_pulse;

  always_ff @(posedge i_brd_clk or negedge i_brd_rst_n) begin
    if (!i_brd_rst_n) begin
      level_q       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      level_q       <= btn_level;
      press_pulse   <= btn_level & ~level_q;
      release_pulse <= ~btn_level & level_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Reset FSM. brd_rst is its own flop, loaded alongside every state change
  // with (next state != RUN), so the board reset never sees decode glitches.
  // The hold counter is shared between POR and STRETCH.
  // ---------------------------------------------------------------------------
  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              brd_rst;

  always_ff @(posedge i_brd_clk or negedge i_brd_rst_n) begin
    if (!i_brd_rst_n) begin
      state    <= ST_POR;
      hold_cnt <= '0;
      brd_rst  <= 1'b1;
    end else begin
      case (state)
        ST_POR: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
            // A button already held through power-up goes straight to
            // PRESSED so reset never blips low.
            if (btn_level) begin
              state   <= ST_PRESSED;
              brd_rst <= 1'b1;
            end else begin
              state   <= ST_RUN;
              brd_rst <= 1'b0;
            end
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        ST_RUN: begin
          if (press_pulse) begin
            state   <= ST_PRESSED;
            brd_rst <= 1'b1;
          end
        end

        ST_PRESSED: begin
          if (release_pulse) begin
            state    <= ST_STRETCH;
            hold_cnt <= '0;
          end
        end

        ST_STRETCH: begin
          // A re-press wins over the terminal count so reset stays high.
          if (press_pulse) begin
            state    <= ST_PRESSED;
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state    <= ST_RUN;
            hold_cnt <= '0;
            brd_rst  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        default: begin
          state    <= ST_POR;
          hold_cnt <= '0;
          brd_rst  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.o_brd_rst       = brd_rst;
  assign bus.o_btn_level     = btn_level;
  assign bus.o_press_pulse   = press_pulse;
  assign bus.o_release_pulse = release_pulse;
  assign bus.o_state         = state;

endmodule

// File: tb/tb_brd_reset_button.sv
// -----------------------------------------------------------------------------
// tb_brd_reset_button
//   Two conditioners share the clock: dut 0 uses DEBOUNCE_CNT=8,
//   RST_HOLD_CNT=4; dut 1 uses DEBOUNCE_CNT=8, RST_HOLD_CNT=16 so that a
//   debounced re-press can land inside STRETCH and a debounced press can
//   complete inside POR. Stimulus pushes cycle-stamped expectations; the
//   monitor compares them and every strobe the DUTs emit.
// -----------------------------------------------------------------------------
module tb_brd_reset_button;

  localparam logic [1:0] S_POR     = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_PRESSED = 2'd2;
  localparam logic [1:0] S_STRETCH = 2'd3;

  logic clk;
  logic rst_n_a;
  logic rst_n_b;

  brd_reset_button_if bus_a ();
  brd_reset_button_if bus_b ();

  brd_reset_button #(
    .DEBOUNCE_CNT  (8),
    .RST_HOLD_CNT  (4),
    .BTN_ACTIVE_LOW(1'b1)
  ) u_dut_a (
    .i_brd_clk  (clk),
    .i_brd_rst_n(rst_n_a),
    .bus        (bus_a)
  );

  brd_reset_button #(
    .DEBOUNCE_CNT  (8),
    .RST_HOLD_CNT  (16),
    .BTN_ACTIVE_LOW(1'b1)
  ) u_dut_b (
    .i_brd_clk  (clk),
    .i_brd_rst_n(rst_n_b),
    .bus        (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         dut;
    int         cyc;
    logic [1:0] st;
    logic       rst;
    logic       lvl;
  } exp_t;

  typedef struct {
    int dut;
    int cyc;
    bit press;
  } pexp_t;

  exp_t  exp_q[$];
  pexp_t pulse_q[$];

  int checks = 0;
  int errors = 0;
  bit finishing = 1'b0;

  logic [1:0] mon_st  [2];
  logic       mon_rst [2];
  logic       mon_lvl [2];
  logic       mon_pp  [2];
  logic       mon_rp  [2];

  assign mon_st[0]  = bus_a.o_state;
  assign mon_rst[0] = bus_a.o_brd_rst;
  assign mon_lvl[0] = bus_a.o_btn_level;
  assign mon_pp[0]  = bus_a.o_press_pulse;
  assign mon_rp[0]  = bus_a.o_release_pulse;
  assign mon_st[1]  = bus_b.o_state;
  assign mon_rst[1] = bus_b.o_brd_rst;
  assign mon_lvl[1] = bus_b.o_btn_level;
  assign mon_pp[1]  = bus_b.o_press_pulse;
  assign mon_rp[1]  = bus_b.o_release_pulse;

  task automatic expect_st(input int d, input int c, input logic [1:0] s,
                           input logic r, input logic l);
    exp_t e;
    e.dut = d; e.cyc = c; e.st = s; e.rst = r; e.lvl = l;
    exp_q.push_back(e);
  endtask

  task automatic expect_pulse(input int d, input int c, input bit press);
    pexp_t p;
    p.dut = d; p.cyc = c; p.press = press;
    pulse_q.push_back(p);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        int d;
        d = exp_q[i].dut;
        checks++;
        if (mon_st[d] !== exp_q[i].st || mon_rst[d] !== exp_q[i].rst ||
            mon_lvl[d] !== exp_q[i].lvl) begin
          errors++;
          $display("FAIL trace dut%0d cyc %0d: got state=%0d rst=%0b level=%0b, expected state=%0d rst=%0b level=%0b",
                   d, cyc, mon_st[d], mon_rst[d], mon_lvl[d],
                   exp_q[i].st, exp_q[i].rst, exp_q[i].lvl);
        end
        exp_q.delete(i);
      end
    end

    for (int d = 0; d < 2; d++) begin
      if (mon_pp[d] || mon_rp[d]) begin
        int idx;
        idx = -1;
        for (int j = 0; j < pulse_q.size(); j++)
          if (idx < 0 && pulse_q[j].dut == d) idx = j;
        checks++;
        if (idx < 0) begin
          errors++;
          $display("FAIL pulse dut%0d cyc %0d: got press=%0b release=%0b, expected no pulse",
                   d, cyc, mon_pp[d], mon_rp[d]);
        end else begin
          if (pulse_q[idx].cyc != cyc || mon_pp[d] !== pulse_q[idx].press ||
              mon_rp[d] === pulse_q[idx].press) begin
            errors++;
            $display("FAIL pulse dut%0d cyc %0d: got press=%0b release=%0b, expected press=%0b at cyc %0d",
                     d, cyc, mon_pp[d], mon_rp[d], pulse_q[idx].press, pulse_q[idx].cyc);
          end
          pulse_q.delete(idx);
        end
      end
    end

    if (finishing) begin
      foreach (exp_q[i]) begin
        checks++;
        errors++;
        $display("FAIL trace dut%0d cyc %0d: got no sample, expected state=%0d rst=%0b level=%0b",
                 exp_q[i].dut, exp_q[i].cyc, exp_q[i].st, exp_q[i].rst, exp_q[i].lvl);
      end
      foreach (pulse_q[i]) begin
        checks++;
        errors++;
        $display("FAIL pulse dut%0d: got none, expected press=%0b at cyc %0d",
                 pulse_q[i].dut, pulse_q[i].press, pulse_q[i].cyc);
      end
      exp_q.delete();
      pulse_q.delete();
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got cyc %0d, expected bench to finish", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int c;
    int b;
    logic [1:0] s;
    logic       l;

    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    bus_a.i_btn_raw = 1'b1;
    bus_b.i_btn_raw = 1'b1;

    // Reset values while held
    wait_neg(1);
    c = cyc;
    for (int k = 1; k <= 3; k++) expect_st(0, c + k, S_POR, 1'b1, 1'b0);
    expect_st(1, c + 2, S_POR, 1'b1, 1'b0);
    wait_neg(4);

    // Power-up hold on dut 0: POR for edges 1-3, RUN from edge 4
    c = cyc;
    rst_n_a = 1'b1;
    for (int k = 1; k <= 3; k++) expect_st(0, c + k, S_POR, 1'b1, 1'b0);
    for (int k = 4; k <= 7; k++) expect_st(0, c + k, S_RUN, 1'b0, 1'b0);
    wait_until(c + 8);

    // Bounce rejection: 3-cycle runs never reach the debounce count
    c = cyc;
    for (int k = 10; k <= 60; k += 10) expect_st(0, c + k, S_RUN, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      bus_a.i_btn_raw = ((i % 2) == 0) ? 1'b0 : 1'b1;
      wait_neg(3);
    end
    bus_a.i_btn_raw = 1'b1;
    expect_st(0, cyc + 20, S_RUN, 1'b0, 1'b0);
    wait_until(cyc + 20);

    // Clean press held 40 cycles
    c = cyc;
    bus_a.i_btn_raw = 1'b0;
    b = c + 1;
    expect_st(0, b + 8,  S_RUN,     1'b0, 1'b0);
    expect_st(0, b + 9,  S_RUN,     1'b0, 1'b1);
    expect_st(0, b + 10, S_RUN,     1'b0, 1'b1);
    expect_st(0, b + 11, S_PRESSED, 1'b1, 1'b1);
    expect_st(0, b + 39, S_PRESSED, 1'b1, 1'b1);
    expect_pulse(0, b + 10, 1'b1);
    wait_until(b + 39);

    // Release and 4-cycle stretch
    c = cyc;
    bus_a.i_btn_raw = 1'b1;
    b = c + 1;
    expect_st(0, b + 8,  S_PRESSED, 1'b1, 1'b1);
    expect_st(0, b + 9,  S_PRESSED, 1'b1, 1'b0);
    expect_st(0, b + 10, S_PRESSED, 1'b1, 1'b0);
    expect_st(0, b + 11, S_STRETCH, 1'b1, 1'b0);
    expect_st(0, b + 14, S_STRETCH, 1'b1, 1'b0);
    expect_st(0, b + 15, S_RUN,     1'b0, 1'b0);
    expect_st(0, b + 20, S_RUN,     1'b0, 1'b0);
    expect_pulse(0, b + 10, 1'b0);
    wait_until(b + 20);

    // Press again, then async reset between edges while PRESSED
    c = cyc;
    bus_a.i_btn_raw = 1'b0;
    b = c + 1;
    expect_st(0, b + 11, S_PRESSED, 1'b1, 1'b1);
    expect_pulse(0, b + 10, 1'b1);
    wait_until(b + 14);
    @(posedge clk);
    #2;
    rst_n_a = 1'b0;
    expect_st(0, cyc, S_POR, 1'b1, 1'b0);
    wait_neg(3);

    // After release with the button still down, debounce restarts from idle
    c = cyc;
    rst_n_a = 1'b1;
    for (int k = 1; k <= 3; k++) expect_st(0, c + k, S_POR, 1'b1, 1'b0);
    expect_pulse(0, c + 11, 1'b1);
    expect_st(0, c + 12, S_PRESSED, 1'b1, 1'b1);
    expect_st(0, c + 15, S_PRESSED, 1'b1, 1'b1);
    wait_until(c + 15);

    // dut 1 power-up: 16-cycle hold
    c = cyc;
    rst_n_b = 1'b1;
    expect_st(1, c + 1,  S_POR, 1'b1, 1'b0);
    expect_st(1, c + 15, S_POR, 1'b1, 1'b0);
    expect_st(1, c + 16, S_RUN, 1'b0, 1'b0);
    wait_until(c + 18);

    // dut 1 clean press
    c = cyc;
    bus_b.i_btn_raw = 1'b0;
    b = c + 1;
    expect_pulse(1, b + 10, 1'b1);
    expect_st(1, b + 11, S_PRESSED, 1'b1, 1'b1);
    wait_until(b + 20);

    // Release, then re-press one cycle into STRETCH: reset never drops
    c = cyc;
    bus_b.i_btn_raw = 1'b1;
    b = c + 1;
    for (int e = 0; e <= 30; e++) begin
      s = (e < 11) ? S_PRESSED : ((e < 23) ? S_STRETCH : S_PRESSED);
      l = (e < 9) ? 1'b1 : ((e < 21) ? 1'b0 : 1'b1);
      expect_st(1, b + e, s, 1'b1, l);
    end
    expect_pulse(1, b + 10, 1'b0);
    expect_pulse(1, b + 22, 1'b1);
    wait_until(b + 11);
    bus_b.i_btn_raw = 1'b0;
    wait_until(b + 30);

    // Later release gives a fresh full stretch
    c = cyc;
    bus_b.i_btn_raw = 1'b1;
    b = c + 1;
    expect_pulse(1, b + 10, 1'b0);
    expect_st(1, b + 11, S_STRETCH, 1'b1, 1'b0);
    expect_st(1, b + 26, S_STRETCH, 1'b1, 1'b0);
    expect_st(1, b + 27, S_RUN,     1'b0, 1'b0);
    wait_until(b + 28);

    // Async reset mid-PRESSED on dut 1, button held: POR -> PRESSED
    c = cyc;
    bus_b.i_btn_raw = 1'b0;
    b = c + 1;
    expect_pulse(1, b + 10, 1'b1);
    expect_st(1, b + 11, S_PRESSED, 1'b1, 1'b1);
    wait_until(b + 14);
    @(posedge clk);
    #2;
    rst_n_b = 1'b0;
    expect_st(1, cyc, S_POR, 1'b1, 1'b0);
    wait_neg(3);

    c = cyc;
    rst_n_b = 1'b1;
    for (int k = 1; k <= 15; k++)
      expect_st(1, c + k, S_POR, 1'b1, (k >= 10) ? 1'b1 : 1'b0);
    for (int k = 16; k <= 20; k++)
      expect_st(1, c + k, S_PRESSED, 1'b1, 1'b1);
    expect_pulse(1, c + 11, 1'b1);
    wait_until(c + 22);

    wait_neg(2);
    finishing = 1'b1;
    wait_neg(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/brd_reset_button.md
Name: brd_reset_button

Overview:
- Conditions the raw board reset push-button into a clean, glitch-free, active-high board reset that drives i_brd_rst of the clocks/resets block.
- Sits directly upstream of the clocks/resets block, in the board crystal clock domain.
- Contains a 2-flop synchroniser, a debounce counter, and a reset-stretch FSM.
- Also asserts reset for a fixed period after power-up/configuration.

Parameters:
- DEBOUNCE_CNT, 1000000, consecutive stable cycles required to accept a button level change (10 ms at 100 MHz); legal values are at least 2.
- RST_HOLD_CNT, 256, cycles o_brd_rst stays asserted after power-up and after button release; legal values are at least 1.
- BTN_ACTIVE_LOW, 1, value 1 means the raw button reads 0 when pressed.

Ports:
- i_brd_clk  input  1  board crystal clock; the only clock.
- i_brd_rst_n  input  1  reset, asynchronous, active-low.
- i_btn_raw  input  1  raw button pin; asynchronous and bouncing.
- o_brd_rst  output  1  registered active-high board reset; feeds i_brd_rst downstream.
- o_btn_level  output  1  debounced button state; 1 = pressed.
- o_press_pulse  output  1  one-cycle strobe on debounced press.
- o_release_pulse  output  1  one-cycle strobe on debounced release.
- o_state  output  2  FSM state for debug: 0=POR, 1=RUN, 2=PRESSED, 3=STRETCH.

Behaviour:
- Reset (i_brd_rst_n=0) acts immediately, without waiting for a clock edge. While it is low:
  - o_brd_rst=1, o_btn_level=0, both pulse outputs=0, o_state=POR.
  - Both synchroniser flops hold the inactive raw level (1 if BTN_ACTIVE_LOW, else 0).
  - All counters are 0.
- Synchroniser: raw -> s1 -> s2 on each edge. Pressed is s2 XOR BTN_ACTIVE_LOW, normalised to 1 = pressed.
- Debounce counter, width $clog2(DEBOUNCE_CNT):
  - If pressed equals o_btn_level, the counter clears to 0.
  - Otherwise, if the counter equals DEBOUNCE_CNT-1, o_btn_level takes the pressed value and the counter clears.
  - Otherwise the counter increments.
  - Any single-cycle return to the stable level restarts the count from 0.
  - The counter must never wrap.
- Latency: raw first sampled at its new level on edge 0 -> o_btn_level changes on edge DEBOUNCE_CNT+1, provided raw is held stable throughout.
- Pulse outputs:
  - o_press_pulse and o_release_pulse are registered, high for exactly the one cycle after o_btn_level rises or falls respectively.
  - The two pulses are never high in the same cycle.
- FSM, registered; o_brd_rst = (state != RUN), registered together with the state:
  - POR: hold counter increments each edge; when it equals RST_HOLD_CNT-1, go to RUN. o_brd_rst therefore deasserts on edge RST_HOLD_CNT after reset release, edges counted from 1. If the button is already debounced as pressed while in POR, go to PRESSED instead of RUN.
  - RUN: on o_press_pulse, go to PRESSED. o_brd_rst rises on the edge after the press-pulse cycle.
  - PRESSED: stay while o_btn_level=1. On o_release_pulse, go to STRETCH and clear the hold counter.
  - STRETCH: counter increments each edge; when it equals RST_HOLD_CNT-1, go to RUN. o_brd_rst falls RST_HOLD_CNT edges after entering STRETCH. A new o_press_pulse during STRETCH returns to PRESSED and abandons the count; o_brd_rst stays 1 with no gap.
- o_brd_rst must be driven directly from a flop, with no combinational decode, so it is glitch-free.
- Asynchronous reset mid-operation, in any state, forces the reset values immediately. The next debounce starts from the inactive level.
- There is a single hold counter, width $clog2(RST_HOLD_CNT)+1, shared by POR and STRETCH.

Test Plan (DEBOUNCE_CNT=8, RST_HOLD_CNT=4, BTN_ACTIVE_LOW=1):
- Power-up: hold i_brd_rst_n=0 for 5 cycles with raw=1, then release -> o_brd_rst=1, o_state=0 for edges 1-3; o_brd_rst=0, o_state=1 from edge 4; no pulses.
- Clean press: drive raw=0 from edge 0 and hold for 40 cycles -> o_btn_level=1 at edge 9; o_press_pulse high for 1 cycle at edge 10; o_brd_rst=1 and o_state=2 from edge 11.
- Bounce rejection: toggle raw every 3 cycles for 60 cycles, then hold raw=1 -> o_btn_level stays 0, no pulses, o_brd_rst stays 0.
- Release stretch: after a clean press, set raw=1 at edge 0 -> o_btn_level=0 at edge 9; o_release_pulse at edge 10; STRETCH from edge 11; o_brd_rst=0 and RUN at edge 15.
- Re-press in STRETCH: press cleanly again 1 cycle after entering STRETCH -> o_state returns to 2; o_brd_rst never drops to 0; a later release gives a fresh 4-cycle stretch.
- Async reset mid-PRESSED: pull i_brd_rst_n low between clock edges -> immediately o_brd_rst=1, o_btn_level=0, o_state=0. After release with raw=0 held, the sequence is POR -> PRESSED with no RUN cycle, and o_brd_rst stays 1 throughout.
